uart_bus_ctrl: RTL

Memory-mapped UART controller between the single-cycle MIPS CPU data bus and the UART byte cores (TX serializer, RX deserializer). Sequences each CPU-initiated transmit through a start/busy/done handshake with the TX core, buffers received bytes, and exposes status bits and an interrupt line. Sits in the peripheral address decode beside the LED and 7-segment registers.

---
 rtl/uart_bus_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: TX handshake FSM, RX buffer, status, irq.
// Optional macro UART_RX_FIFO_EN selects a FIFO_DEPTH-entry RX FIFO.
module uart_bus_ctrl #(
   parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
   parameter logic [31:0] ADDR_RXD   = 32'h4000_001C,
   parameter logic [31:0] ADDR_CON   = 32'h4000_0020,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_status,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_ACK,
      S_WAIT_DONE
   } tx_state_t;

   tx_state_t  r_state;
   logic [7:0] r_tx_data;
   logic       r_tx_start;
   logic       r_tx_irq_en;
   logic       r_rx_irq_en;
   logic       r_tx_done;
   logic       r_rx_overrun;

   logic       w_sel_txd;
   logic       w_sel_rxd;
   logic       w_sel_con;
   logic       w_wr_txd;
   logic       w_wr_con;
   logic       w_rd_rxd;
   logic       w_rd_con;
   logic       w_tx_busy;
   logic       w_done_set;
   logic       w_rx_empty;
   logic       w_rx_full;
   logic [7:0] w_rx_head;
   logic       w_pop;
   logic       w_push;
   logic       w_ovf_set;
   logic       w_unused_wdata;

   assign w_sel_txd  = (addr == ADDR_TXD);
   assign w_sel_rxd  = (addr == ADDR_RXD);
   assign w_sel_con  = (addr == ADDR_CON);
   assign w_wr_txd   = wr & w_sel_txd;
   assign w_wr_con   = wr & w_sel_con;
   assign w_rd_rxd   = rd & w_sel_rxd;
   assign w_rd_con   = rd & w_sel_con;
   assign w_tx_busy  = (r_state != S_IDLE);
   assign w_done_set = (r_state == S_WAIT_DONE) & tx_status;

   // A full buffer still accepts a byte when the same edge pops one.
   assign w_pop      = w_rd_rxd & ~w_rx_empty;
   assign w_push     = rx_valid & (~w_rx_full | w_pop);
   assign w_ovf_set  = rx_valid & w_rx_full & ~w_pop;

   assign w_unused_wdata = ^wdata[31:8];

   // TX handshake sequencer with registered start pulse and data latch
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_wr_txd) begin
                  r_tx_data  <= wdata[7:0];
                  r_tx_start <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!tx_status) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (tx_status) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Control enables and sticky status; a set on the same edge beats a read-clear
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_tx_irq_en  <= 1'b0;
         r_rx_irq_en  <= 1'b0;
         r_tx_done    <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_wr_con) begin
            r_tx_irq_en <= wdata[0];
            r_rx_irq_en <= wdata[1];
         end
         if (w_done_set)    r_tx_done <= 1'b1;
         else if (w_rd_con) r_tx_done <= 1'b0;
         if (w_ovf_set)     r_rx_overrun <= 1'b1;
         else if (w_rd_con) r_rx_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   assign w_rx_empty = (r_count == '0);
   assign w_rx_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_rx_head  = r_mem[r_rptr];

   // RX FIFO storage array, written at the tail
   always_ff @(posedge sysclk) begin
      if (w_push) r_mem[r_wptr] <= rx_data;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end
`else
   logic [7:0] r_hold;
   logic       r_hold_vld;
   logic       w_unused_depth;

   assign w_unused_depth = (FIFO_DEPTH == 0);
   assign w_rx_empty     = ~r_hold_vld;
   assign w_rx_full      = r_hold_vld;
   assign w_rx_head      = r_hold;

   // Single-byte RX holding register; push wins over pop
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_hold     <= 8'h00;
         r_hold_vld <= 1'b0;
      end else if (w_push) begin
         r_hold     <= rx_data;
         r_hold_vld <= 1'b1;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end
`endif

   // Combinational read mux, zero unless a register is selected
   always_comb begin
      rdata = 32'h0;
      if (rd) begin
         unique case (1'b1)
            w_sel_txd: rdata = {24'h0, r_tx_data};
            w_sel_rxd: rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            w_sel_con: rdata = {26'h0, r_rx_overrun, w_tx_busy,
                                ~w_rx_empty, r_tx_done,
                                r_rx_irq_en, r_tx_irq_en};
            default:   rdata = 32'h0;
         endcase
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign irq      = (r_tx_irq_en & r_tx_done) | (r_rx_irq_en & ~w_rx_empty);

endmodule
